instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Upstream fetch stage for the 32-bit MIPS core. It owns the PC and fetches one instruction at a time from an instruction memory with variable latency. It presents a registered instruction to the control unit and datapath, and computes the next PC from the control unit's Jmp/PCSrc and the sign-extended immediate. A stall input lets downstream multi-cycle operations (e.g. MUL) hold the current instruction in place.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] ignored, forced 0)
TIMEOUT, 16, max cycles to wait for imem_ready before faulting; 0 disables timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request, held high until imem_ready
imem_addr  output  32  fetch address (= PC), stable while imem_req high
imem_ready  input  1  imem_rdata valid this cycle; completes request
imem_rdata  input  32  fetched instruction word
Instruction  output  32  registered instruction to control unit/datapath
instr_valid  output  1  Instruction is valid and executing
instr_retire  output  1  instruction completes this cycle; downstream qualifies RegWrite/MemWrite with it
pc  output  32  address of current Instruction
pc_plus4  output  32  pc + 4
Jmp  input  1  from control unit
PCSrc  input  1  from control unit (Branch & Zero)
SignImm  input  32  sign-extended immediate from datapath
stall  input  1  downstream busy; hold current instruction
fetch_err  output  1  sticky fetch timeout fault
retired_cnt  output  CNT_W  count of retired instructions

Behaviour:
- Reset: pc=RESET_PC&~3, Instruction=0, instr_valid=0, instr_retire=0, fetch_err=0, retired_cnt=0, wait counter=0, state=FETCH. imem_req is high in the first cycle after reset deasserts.
- States: FETCH, EXEC, FAULT.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - If imem_ready: Instruction<=imem_rdata, wait counter<=0, go to EXEC. Zero-wait is allowed (ready in the first req cycle).
  - Otherwise the wait counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ready, go to FAULT.
- EXEC:
  - imem_req=0, instr_valid=1, instr_retire=!stall (combinational).
  - On retire: pc<=next_pc, retired_cnt+=1 (wraps at 2^CNT_W), go to FETCH.
  - With stall=1: pc, Instruction and state are held. Jmp/PCSrc are ignored until the retire cycle.
- next_pc (combinational, 32-bit modular arithmetic):
  - Jmp=1: {pc_plus4[31:28], Instruction[25:0], 2'b00}.
  - else PCSrc=1: pc_plus4 + (SignImm<<2).
  - else pc_plus4.
  - Jmp has priority over PCSrc when both are high.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, with no fault.
- FAULT: imem_req=0, instr_valid=0, instr_retire=0, fetch_err=1. Only rst leaves this state.
- imem_ready outside FETCH is ignored. imem_rdata is ignored unless imem_ready is high in FETCH.
- Reset mid-fetch drops the outstanding request, with no retire. The memory must tolerate a req being withdrawn.
- Throughput: at most one instruction per 2 cycles (zero-wait memory, no stall).

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (R-type, LW, SW, ADDI, BEQ, J)
  - fetch state enum {FETCH, EXEC, FAULT}
  - ALUControl encodings
- One combinational sub-module, next_pc_calc: inputs pc, Instruction, SignImm, Jmp, PCSrc; outputs pc_plus4, next_pc.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, zero-wait memory returning 32'h2008_0005 -> first req addr 0x40; instr_valid in cycle 2; retire; next req addr 0x44; retired_cnt=1.
- Memory ready after 3 wait cycles, TIMEOUT=16 -> imem_addr held stable 4 cycles, Instruction captured only on the ready cycle, no fault.
- BEQ at pc=0x100 with PCSrc=1, SignImm=32'hFFFF_FFFE -> next req addr 0x0FC. Same with PCSrc=0 -> 0x104.
- J instruction 32'h0800_0010 at pc=0x1000_0000 with Jmp=1, PCSrc=1 -> next addr 0x1000_0040 (Jmp wins).
- stall high 5 cycles in EXEC -> instr_valid=1, instr_retire=0, pc unchanged, retired_cnt unchanged; retires on the first cycle stall=0.
- imem_ready never asserted, TIMEOUT=4 -> FAULT after 4 req cycles; fetch_err=1 and imem_req=0 until rst; rst restores fetch from RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, fetch FSM states and ALU control encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump target over branch target over sequential, all modulo 2^32.
// Purely combinational, no flow control.
module next_pc_calc (
  input  logic [31:0] pc,
  input  logic [31:0] Instruction,
  input  logic [31:0] SignImm,
  input  logic        Jmp,
  input  logic        PCSrc,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  // Opcode bits are decoded by the control unit, not needed here.
  logic unused_opcode;
  assign unused_opcode = ^Instruction[31:26];

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (Jmp)
      next_pc = {pc_plus4[31:28], Instruction[25:0], 2'b00};
    else if (PCSrc)
      next_pc = pc_plus4 + {SignImm[29:0], 2'b00};
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, registered instruction, 2-cycle minimum per instruction.
// stall holds the executing instruction; a memory that never answers within TIMEOUT cycles faults until reset.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      Instruction,
  output logic             instr_valid,
  output logic             instr_retire,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             Jmp,
  input  logic             PCSrc,
  input  logic [31:0]      SignImm,
  input  logic             stall,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [1:0]  ST_FETCH  = FETCH;
  localparam logic [1:0]  ST_EXEC   = EXEC;
  localparam logic [1:0]  ST_FAULT  = FAULT;
  localparam logic [31:0] PC_INIT   = RESET_PC & ~32'd3;
  localparam int          WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       next_pc;

  next_pc_calc u_next_pc (
    .pc          (pc),
    .Instruction (Instruction),
    .SignImm     (SignImm),
    .Jmp         (Jmp),
    .PCSrc       (PCSrc),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc)
  );

  assign imem_req     = (state == ST_FETCH);
  assign imem_addr    = pc;
  assign instr_valid  = (state == ST_EXEC);
  assign instr_retire = (state == ST_EXEC) && !stall;
  assign fetch_err    = (state == ST_FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= PC_INIT;
      Instruction <= 32'd0;
      wait_cnt    <= '0;
      retired_cnt <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            Instruction <= imem_rdata;
            wait_cnt    <= '0;
            state       <= ST_EXEC;
          end else if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
            state <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            pc          <= next_pc;
            retired_cnt <= retired_cnt + CNT_W'(1);
            state       <= ST_FETCH;
          end
        end
        ST_FAULT: state <= ST_FAULT;  // only rst leaves
        default:  state <= ST_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, wait states, branch/jump, stall, PC wrap, timeout fault.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic        instr_retire;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Jmp = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] SignImm = 32'd0;
  logic        stall = 1'b0;
  logic        fetch_err;
  logic [31:0] retired_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0040),
    .TIMEOUT  (4),
    .CNT_W    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .Instruction  (Instruction),
    .instr_valid  (instr_valid),
    .instr_retire (instr_retire),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .Jmp          (Jmp),
    .PCSrc        (PCSrc),
    .SignImm      (SignImm),
    .stall        (stall),
    .fetch_err    (fetch_err),
    .retired_cnt  (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve the pending request after 'waits' idle cycles; leaves the DUT in EXEC.
  task automatic serve(input int waits, input logic [31:0] word);
    for (int i = 0; i < waits; i++) begin
      imem_rdata = 32'hDEAD_BEEF;
      tick();
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
  endtask

  task automatic retire(input logic j, input logic s, input logic [31:0] imm);
    Jmp = j; PCSrc = s; SignImm = imm; stall = 1'b0;
    tick();
    Jmp = 1'b0; PCSrc = 1'b0; SignImm = 32'd0;
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL reset_addr got=%h exp=00000040", imem_addr); end
    checks++; if (instr_valid !== 1'b0 || instr_retire !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b%b exp=00", instr_valid, instr_retire); end
    checks++; if (Instruction !== 32'd0) begin errors++; $display("FAIL reset_instr got=%h exp=0", Instruction); end
    checks++; if (fetch_err !== 1'b0 || retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_err_cnt got=%b/%0d exp=0/0", fetch_err, retired_cnt); end
  endtask

  task automatic test_zero_wait();
    serve(0, 32'h2008_0005);
    checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL zw_valid got=v%b r%b exp=v1 r0", instr_valid, imem_req); end
    checks++; if (Instruction !== 32'h2008_0005) begin errors++; $display("FAIL zw_instr got=%h exp=20080005", Instruction); end
    checks++; if (instr_retire !== 1'b1) begin errors++; $display("FAIL zw_retire got=%b exp=1", instr_retire); end
    checks++; if (pc !== 32'h40 || pc_plus4 !== 32'h44) begin errors++; $display("FAIL zw_pc got=%h/%h exp=40/44", pc, pc_plus4); end
    retire(1'b0, 1'b0, 32'd0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin errors++; $display("FAIL zw_next got=%b/%h exp=1/00000044", imem_req, imem_addr); end
    checks++; if (retired_cnt !== 32'd1) begin errors++; $display("FAIL zw_cnt got=%0d exp=1", retired_cnt); end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      imem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44 || instr_valid !== 1'b0) begin errors++; $display("FAIL ws_hold%0d got=%b/%h/%b exp=1/00000044/0", i, imem_req, imem_addr, instr_valid); end
      tick();
      checks++; if (Instruction !== 32'h2008_0005) begin errors++; $display("FAIL ws_nocap%0d got=%h exp=20080005", i, Instruction); end
    end
    checks++; if (imem_addr !== 32'h44) begin errors++; $display("FAIL ws_hold3 got=%h exp=00000044", imem_addr); end
    serve(0, 32'h0800_0040);
    checks++; if (Instruction !== 32'h0800_0040 || instr_valid !== 1'b1) begin errors++; $display("FAIL ws_cap got=%h/%b exp=08000040/1", Instruction, instr_valid); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL ws_err got=%b exp=0", fetch_err); end
    retire(1'b1, 1'b0, 32'd0);
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL ws_jump got=%h exp=00000100", imem_addr); end
  endtask

  task automatic test_branch();
    serve(0, 32'h1000_FFFE);
    retire(1'b0, 1'b1, 32'hFFFF_FFFE);
    checks++; if (imem_addr !== 32'h0FC) begin errors++; $display("FAIL br_taken got=%h exp=000000fc", imem_addr); end
    serve(1, 32'h0800_0040);
    retire(1'b1, 1'b0, 32'd0);
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL br_back got=%h exp=00000100", imem_addr); end
    serve(0, 32'h1000_FFFE);
    retire(1'b0, 1'b0, 32'hFFFF_FFFE);
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL br_nottaken got=%h exp=00000104", imem_addr); end
    serve(0, 32'h1000_0000);
    retire(1'b0, 1'b1, 32'h03FF_FFBE);
    checks++; if (imem_addr !== 32'h1000_0000) begin errors++; $display("FAIL br_far got=%h exp=10000000", imem_addr); end
  endtask

  task automatic test_jump_priority();
    serve(0, 32'h0800_0010);
    retire(1'b1, 1'b1, 32'd5);
    checks++; if (imem_addr !== 32'h1000_0040) begin errors++; $display("FAIL jmp_prio got=%h exp=10000040", imem_addr); end
  endtask

  task automatic test_stall();
    serve(0, 32'h0000_0020);
    stall = 1'b1;
    Jmp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_ready = (i == 2);
      #1;
      checks++; if (instr_valid !== 1'b1 || instr_retire !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL st_flags%0d got=v%b r%b q%b exp=v1 r0 q0", i, instr_valid, instr_retire, imem_req); end
      checks++; if (pc !== 32'h1000_0040 || retired_cnt !== exp_cnt || Instruction !== 32'h20) begin errors++; $display("FAIL st_hold%0d got=%h/%0d/%h exp=10000040/%0d/00000020", i, pc, retired_cnt, Instruction, exp_cnt); end
      tick();
    end
    imem_ready = 1'b0;
    Jmp = 1'b0;
    stall = 1'b0;
    #1;
    checks++; if (instr_retire !== 1'b1) begin errors++; $display("FAIL st_release got=%b exp=1", instr_retire); end
    retire(1'b0, 1'b0, 32'd0);
    checks++; if (imem_addr !== 32'h1000_0044 || retired_cnt !== exp_cnt) begin errors++; $display("FAIL st_after got=%h/%0d exp=10000044/%0d", imem_addr, retired_cnt, exp_cnt); end
  endtask

  task automatic test_pc_wrap();
    serve(0, 32'h1000_0000);
    retire(1'b0, 1'b1, 32'h3BFF_FFED);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got=%h exp=fffffffc", imem_addr); end
    serve(0, 32'h0000_0000);
    checks++; if (pc_plus4 !== 32'd0) begin errors++; $display("FAIL wrap_plus4 got=%h exp=00000000", pc_plus4); end
    retire(1'b0, 1'b0, 32'd0);
    checks++; if (imem_addr !== 32'd0 || fetch_err !== 1'b0) begin errors++; $display("FAIL wrap_zero got=%h/%b exp=00000000/0", imem_addr, fetch_err); end
    checks++; if (retired_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("FAIL to_req%0d got=%b/%b exp=1/0", i, imem_req, fetch_err); end
      tick();
    end
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL to_fault got=%b/%b exp=1/0", fetch_err, imem_req); end
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1;
      tick();
      checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_retire !== 1'b0) begin errors++; $display("FAIL to_sticky%0d got=e%b q%b v%b r%b exp=e1 q0 v0 r0", i, fetch_err, imem_req, instr_valid, instr_retire); end
    end
    imem_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL to_recover got=%b/%b/%h exp=0/1/00000040", fetch_err, imem_req, imem_addr); end
  endtask

  task automatic test_reset_midfetch();
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (retired_cnt !== 32'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst got=%0d/%b exp=0/0", retired_cnt, instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL mid_req got=%b/%h exp=1/00000040", imem_req, imem_addr); end
    serve(2, 32'h2008_0005);
    retire(1'b0, 1'b0, 32'd0);
    checks++; if (retired_cnt !== 32'd1 || imem_addr !== 32'h44) begin errors++; $display("FAIL mid_restart got=%0d/%h exp=1/00000044", retired_cnt, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_jump_priority();
    test_stall();
    test_pc_wrap();
    test_timeout();
    test_reset_midfetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
